// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1-to-8 buffered demux.
// Channel count, address width and the one-hot write-enable decode.
package demux_pkg;

  localparam int NUM_CH = 8;
  localparam int ADDR_W = 3;

  function automatic logic [NUM_CH-1:0] onehot8(
    input logic [ADDR_W-1:0] addr
  );
    logic [NUM_CH-1:0] oh;
    oh = '0;
    oh[addr] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux_chan_slot.sv
// Single-entry channel buffer: a data word plus its valid flag.
// A write on the same edge as an ack keeps the flag set.
module demux_chan_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ack,
  output logic [WIDTH-1:0] q,
  output logic             valid
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             valid_q, valid_d;

  always_comb begin
    q_d     = q_q;
    valid_d = valid_q & ~ack;
    if (wr_en) begin
      q_d     = wdata;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      valid_q <= valid_d;
    end
  end

  assign q     = q_q;
  assign valid = valid_q;

endmodule

// File: rtl/demux_8_buf.sv
// Registered 1-to-8 demux with chip select and scatter-burst pointer.
// Each output channel buffers one word until its consumer acks it.
module demux_8_buf
  import demux_pkg::*;
#(
  parameter int width = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              nCS,
  input  logic [ADDR_W-1:0] addr,
  input  logic              auto_inc,
  input  logic [width-1:0]  din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [width-1:0]  out1,
  output logic [width-1:0]  out2,
  output logic [width-1:0]  out3,
  output logic [width-1:0]  out4,
  output logic [width-1:0]  out5,
  output logic [width-1:0]  out6,
  output logic [width-1:0]  out7,
  output logic [width-1:0]  out8,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ack,
  output logic [ADDR_W-1:0] cur_addr
);

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] tgt;
  logic              wr;
  logic [NUM_CH-1:0] we;
  logic [width-1:0]  q [NUM_CH];

  assign tgt = auto_inc ? ptr_q : addr;

  // A full target may be refilled on the edge its consumer acks it.
  assign din_ready = rst_n & ~nCS &
                     (~out_valid[tgt] | out_ack[tgt]);

  assign wr = din_valid & din_ready;
  assign we = wr ? onehot8(tgt) : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (!nCS) begin
      if (!auto_inc) ptr_d = addr;
      else if (wr)   ptr_d = ptr_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    demux_chan_slot #(.WIDTH(width)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .wr_en (we[i]),
      .wdata (din),
      .ack   (out_ack[i]),
      .q     (q[i]),
      .valid (out_valid[i])
    );
  end

  assign out1     = q[0];
  assign out2     = q[1];
  assign out3     = q[2];
  assign out4     = q[3];
  assign out5     = q[4];
  assign out6     = q[5];
  assign out7     = q[6];
  assign out8     = q[7];
  assign cur_addr = ptr_q;

endmodule

// File: tb/tb_demux_8_buf.sv
// Directed, table-driven bench for demux_8_buf.
// Vectors carry hand-computed expectations; reset cases are hand-written.
module tb_demux_8_buf;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       nCS;
  logic [2:0] addr;
  logic       auto_inc;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [7:0] out1, out2, out3, out4;
  logic [7:0] out5, out6, out7, out8;
  logic [7:0] out_valid;
  logic [7:0] out_ack;
  logic [2:0] cur_addr;
  logic [7:0] outs [8];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux_8_buf #(.width(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .nCS       (nCS),
    .addr      (addr),
    .auto_inc  (auto_inc),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out4      (out4),
    .out5      (out5),
    .out6      (out6),
    .out7      (out7),
    .out8      (out8),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .cur_addr  (cur_addr)
  );

  assign outs[0] = out1;
  assign outs[1] = out2;
  assign outs[2] = out3;
  assign outs[3] = out4;
  assign outs[4] = out5;
  assign outs[5] = out6;
  assign outs[6] = out7;
  assign outs[7] = out8;

  typedef struct {
    logic       ncs;
    logic       ai;
    logic [2:0] ad;
    logic [7:0] d;
    logic       dv;
    logic [7:0] ack;
    logic       e_rdy;
    logic [7:0] e_vld;
    logic [2:0] e_cur;
    int         e_ch;
    logic [7:0] e_dat;
  } vec_t;

  vec_t v [16];

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input int idx);
    @(negedge clk);
    nCS       = t.ncs;
    auto_inc  = t.ai;
    addr      = t.ad;
    din       = t.d;
    din_valid = t.dv;
    out_ack   = t.ack;
    #1;
    chk($sformatf("v%0d ready", idx), {7'd0, din_ready},
        {7'd0, t.e_rdy});
    @(posedge clk);
    #1;
    chk($sformatf("v%0d valid", idx), out_valid, t.e_vld);
    chk($sformatf("v%0d cur", idx), {5'd0, cur_addr},
        {5'd0, t.e_cur});
    chk($sformatf("v%0d out%0d", idx, t.e_ch + 1),
        outs[t.e_ch], t.e_dat);
  endtask

  task automatic chk_clear(input string nm);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s out%0d", nm, i + 1), outs[i], 8'h00);
    chk({nm, " valid"}, out_valid, 8'h00);
    chk({nm, " cur"}, {5'd0, cur_addr}, 8'h00);
    chk({nm, " ready"}, {7'd0, din_ready}, 8'h00);
  endtask

  initial begin
    //        ncs ai ad d      dv ack    rdy vld    cur ch dat
    v[0]  = '{0, 0, 5, 8'hA5, 1, 8'h00, 1, 8'h20, 5, 5, 8'hA5};
    v[1]  = '{0, 0, 2, 8'h33, 1, 8'h00, 1, 8'h24, 2, 2, 8'h33};
    v[2]  = '{0, 0, 2, 8'h11, 1, 8'h00, 0, 8'h24, 2, 2, 8'h33};
    v[3]  = '{0, 0, 2, 8'h22, 1, 8'h04, 1, 8'h24, 2, 2, 8'h22};
    v[4]  = '{0, 0, 6, 8'h00, 0, 8'h24, 1, 8'h00, 6, 5, 8'hA5};
    v[5]  = '{0, 1, 0, 8'h01, 1, 8'h00, 1, 8'h40, 7, 6, 8'h01};
    v[6]  = '{0, 1, 0, 8'h02, 1, 8'h00, 1, 8'hC0, 0, 7, 8'h02};
    v[7]  = '{0, 1, 0, 8'h03, 1, 8'h00, 1, 8'hC1, 1, 0, 8'h03};
    v[8]  = '{0, 1, 0, 8'h04, 1, 8'h00, 1, 8'hC3, 2, 1, 8'h04};
    v[9]  = '{1, 1, 7, 8'h55, 1, 8'h00, 0, 8'hC3, 2, 2, 8'h22};
    v[10] = '{1, 0, 5, 8'h55, 0, 8'hFF, 0, 8'h00, 2, 0, 8'h03};
    v[11] = '{0, 0, 4, 8'h00, 0, 8'h10, 1, 8'h00, 4, 4, 8'h00};
    v[12] = '{0, 0, 4, 8'h9C, 1, 8'h00, 1, 8'h10, 4, 4, 8'h9C};
    v[13] = '{0, 1, 0, 8'h77, 1, 8'h00, 0, 8'h10, 4, 4, 8'h9C};
    v[14] = '{0, 1, 0, 8'h77, 1, 8'h10, 1, 8'h10, 5, 4, 8'h77};
    v[15] = '{0, 0, 0, 8'hE1, 1, 8'h11, 1, 8'h01, 0, 0, 8'hE1};

    rst_n     = 1'b0;
    nCS       = 1'b0;
    auto_inc  = 1'b0;
    addr      = 3'd0;
    din       = 8'h00;
    din_valid = 1'b1;
    out_ack   = 8'h00;
    #12;
    chk_clear("reset");
    @(negedge clk);
    rst_n = 1'b1;
    din_valid = 1'b0;

    for (int i = 0; i < 16; i++) apply(v[i], i);

    // Fill every channel, then reset mid-cycle.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      nCS       = 1'b0;
      auto_inc  = 1'b0;
      addr      = 3'(i);
      din       = 8'(8'hF0 + i);
      din_valid = 1'b1;
      out_ack   = 8'h00;
    end
    @(posedge clk);
    #1;
    chk("fill valid", out_valid, 8'hFF);
    chk("fill out8", out8, 8'hF7);
    #2;
    rst_n = 1'b0;
    #1;
    chk_clear("async rst");

    // Word presented during reset is dropped.
    auto_inc = 1'b1;
    din = 8'hBB;
    @(posedge clk);
    #1;
    chk_clear("rst hold");
    @(negedge clk);
    rst_n = 1'b1;
    din_valid = 1'b0;
    #1;
    chk("rel ready", {7'd0, din_ready}, 8'h01);
    @(posedge clk);
    #1;
    chk("rel valid", out_valid, 8'h00);
    chk("rel cur", {5'd0, cur_addr}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_8_buf.md
Name: demux_8_buf

Overview:
- Registered 1-to-8 demultiplexer with chip select. It routes one input word per cycle to one of eight output channels.
- Each channel holds a single buffered word, flagged valid until its consumer acknowledges it.
- It is the distribution counterpart of the 8:1 selector path: it scatters a shared bus to eight consumers.
- It supports direct addressing, plus an auto-increment (scatter-burst) mode driven by an internal pointer.

Parameters:
- width, 8, data word width in bits (>=1).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- nCS  input  1  active-low chip select; when high, the block accepts nothing.
- addr  input  3  target channel in direct mode (0 selects out1, 7 selects out8).
- auto_inc  input  1  1 targets the internal pointer; 0 targets addr.
- din  input  width  input data word.
- din_valid  input  1  producer has a word on din.
- din_ready  output  1  the block accepts din this cycle (combinational).
- out1..out8  output  width each  channel data registers.
- out_valid  output  8  bit i set means out(i+1) holds an unconsumed word.
- out_ack  input  8  consumer i takes its word this cycle.
- cur_addr  output  3  current internal pointer value.

Behaviour:
- Reset (async, rst_n=0): out1..out8=0, out_valid=8'h00, pointer=0 (cur_addr=0). din_ready=0 while rst_n=0. Release is synchronous to the next rising edge.
- Target selection: tgt = auto_inc ? pointer : addr.
- din_ready = !nCS && (!out_valid[tgt] || out_ack[tgt]).
  - A full channel acked in the same cycle may be refilled in that cycle.
  - din_ready must not depend on din_valid.
- Write occurs when din_valid && din_ready. On that edge: out(tgt+1) <= din and out_valid[tgt] <= 1.
- Latency: a word accepted at edge N is visible on outK with out_valid set after edge N, i.e. in cycle N+1.
- Ack: out_valid[i] clears on an edge where out_ack[i]=1 and out_valid[i]=1, unless a write to channel i occurs on the same edge. In that case the write wins and valid stays 1.
  - Ack on a non-valid channel is ignored.
  - Acks are honoured regardless of nCS.
- Data hold: outK keeps its value after ack; only a write changes it. There is no zeroing on nCS.
- Pointer:
  - auto_inc=1 and a write occurs: pointer <= pointer+1, wrapping 7 to 0.
  - auto_inc=1 and no write: pointer holds.
  - auto_inc=0: pointer <= addr every edge, so a burst starts at the last direct address.
  - nCS=1: pointer holds, irrespective of auto_inc.
- Stall: if the target channel is full and not acked, din_ready=0. The pointer does not advance, and the producer holds din/din_valid.
- nCS=1: din_ready=0 and no writes occur. Channel acks still drain valid flags.
- Reset mid-burst: all state clears immediately; a word being presented is dropped.
- Simultaneous acks on several channels plus one write: all are handled on the same edge and are independent.
- The design holds no combinational path from din to any out.

Decomposition:
- Shared package demux_pkg:
  - NUM_CH=8, ADDR_W=3.
  - Function onehot8(addr) returning an 8-bit one-hot write-enable.
- One natural sub-module: demux_chan_slot (width param).
  - A single-entry holding register with ports clk, rst_n, wr_en, wdata, ack, q, valid, implementing the write-wins-over-ack rule.
  - demux_8_buf instantiates it 8 times and adds target select, ready logic and the pointer.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with out_valid=8'hFF -> outputs clear asynchronously to 0, out_valid=0, cur_addr=0, din_ready=0.
- Direct write: nCS=0, auto_inc=0, addr=5, din=8'hA5, din_valid=1 for one cycle -> next cycle out6=8'hA5, out_valid=8'h20; other outputs unchanged.
- Backpressure and same-cycle refill:
  - With channel 2 full, write addr=2 din=8'h11 and out_ack=0 -> din_ready=0, out3 unchanged.
  - Then assert out_ack[2]=1 with din=8'h22 -> din_ready=1; after the edge out3=8'h22 and out_valid[2] remains 1.
- Auto-increment wrap: addr=6 with auto_inc=0 for one cycle, then auto_inc=1 with 4 back-to-back words 1,2,3,4 -> out7=1, out8=2, out1=3, out2=4, cur_addr=2, out_valid=8'hC3.
- Chip select:
  - nCS=1 with din_valid=1 -> din_ready=0, no channel written, pointer holds.
  - out_ack=8'hFF clears all valid flags in one edge.
- Ack on empty channel: out_ack[4]=1 with out_valid[4]=0 -> no state change; then a write to channel 4 sets valid normally.
